// File: rtl/branch_hazard_if.sv
// Branch hazard control bundle.
// Groups the decode-stage branch request, the EX/MEM producer info, the
// external freeze/flush requests and all controller outputs.
//   master : pipeline side (drives branch/producer info, reads controls)
//   slave  : branch_hazard_ctrl (reads branch/producer info, drives controls)
interface branch_hazard_if;
    logic        isBranchD;
    logic        isB;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        usesRtD;
    logic [31:0] branch_targetD;
    logic        regwriteE;
    logic        memtoregE;
    logic [4:0]  writeregE;
    logic        regwriteM;
    logic        memtoregM;
    logic [4:0]  writeregM;
    logic        stall_ext;
    logic        flush_exc;
    logic        stallF;
    logic        stallD;
    logic        flushE;
    logic        forwardAD;
    logic        forwardBD;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output isBranchD, isB, rsD, rtD, usesRtD, branch_targetD,
               regwriteE, memtoregE, writeregE,
               regwriteM, memtoregM, writeregM,
               stall_ext, flush_exc,
        input  stallF, stallD, flushE, forwardAD, forwardBD,
               pc_redirect, pc_target, branch_cnt, taken_cnt, stall_cnt
    );

    modport slave (
        input  isBranchD, isB, rsD, rtD, usesRtD, branch_targetD,
               regwriteE, memtoregE, writeregE,
               regwriteM, memtoregM, writeregM,
               stall_ext, flush_exc,
        output stallF, stallD, flushE, forwardAD, forwardBD,
               pc_redirect, pc_target, branch_cnt, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch hazard controller.
// Stalls a decode-stage branch while its comparator operands are still being
// produced in EX (any write) or MEM (load), forwards MEM ALU results to the
// comparator, and issues a single-cycle PC redirect for taken branches. When
// a taken branch resolves under an external freeze, the target is held and
// the redirect is issued on the first unfrozen cycle.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset (forces all outputs to 0)
//   bus    : branch_hazard_if.slave (inputs/controls/statistics)
// Build option: define BRANCH_STAT_EN to include the branch/taken/stall
// statistics counters; otherwise the counter outputs are tied to 0.
module branch_hazard_ctrl (
    input  logic           clk,
    input  logic           resetn,
    branch_hazard_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, HOLD = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] tgt_q, tgt_nxt;
    logic        hazard;
    logic        fwd_a, fwd_b;
    logic        stall_f, stall_d, flush_e;
    logic        redirect;
    logic [31:0] target;
    logic        resolve;
    logic        stall_hz;
    logic        unused_memtoreg_e;

    // An EX load is already covered by its regwriteE, so memtoregE carries no
    // extra information for the decode-stage comparator.
    assign unused_memtoreg_e = bus.memtoregE;

    function automatic logic src_match(input logic [4:0] wr, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rt);
        return (wr != 5'd0) && ((wr == rs) || (use_rt && (wr == rt)));
    endfunction

    // Writeback producers are absent on purpose: the register file writes in
    // the first half-cycle, so decode already reads the new value.
    assign hazard = bus.isBranchD &&
                    ((bus.regwriteE && src_match(bus.writeregE, bus.rsD, bus.rtD, bus.usesRtD)) ||
                     (bus.memtoregM && src_match(bus.writeregM, bus.rsD, bus.rtD, bus.usesRtD)));

    assign fwd_a = bus.regwriteM && !bus.memtoregM && (bus.writeregM != 5'd0) &&
                   (bus.writeregM == bus.rsD);
    assign fwd_b = bus.regwriteM && !bus.memtoregM && (bus.writeregM != 5'd0) &&
                   bus.usesRtD && (bus.writeregM == bus.rtD);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            tgt_q <= 32'd0;
        end else begin
            state <= state_nxt;
            tgt_q <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        stall_f   = bus.stall_ext;
        stall_d   = bus.stall_ext;
        flush_e   = 1'b0;
        redirect  = 1'b0;
        target    = 32'd0;
        resolve   = 1'b0;
        stall_hz  = 1'b0;
        if (bus.flush_exc) begin
            // Exception flush wins: drop any pending redirect and unfreeze.
            state_nxt = IDLE;
            tgt_nxt   = 32'd0;
            stall_f   = 1'b0;
            stall_d   = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (!bus.stall_ext) begin
                        redirect  = 1'b1;
                        target    = tgt_q;
                        tgt_nxt   = 32'd0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    if (hazard) begin
                        state_nxt = STALL;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        flush_e   = 1'b1;
                        stall_hz  = 1'b1;
                    end else if (bus.isBranchD) begin
                        resolve = 1'b1;
                        if (bus.isB) begin
                            if (bus.stall_ext) begin
                                tgt_nxt   = bus.branch_targetD;
                                state_nxt = HOLD;
                            end else begin
                                redirect = 1'b1;
                                target   = bus.branch_targetD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Outputs are gated by resetn so they drop immediately on reset, even the
    // purely combinational pass-through and forwarding paths.
    assign bus.stallF      = resetn & stall_f;
    assign bus.stallD      = resetn & stall_d;
    assign bus.flushE      = resetn & flush_e;
    assign bus.forwardAD   = resetn & fwd_a;
    assign bus.forwardBD   = resetn & fwd_b;
    assign bus.pc_redirect = resetn & redirect;
    assign bus.pc_target   = resetn ? target : 32'd0;

`ifdef BRANCH_STAT_EN
    logic [31:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;

    // Flush cycles never set resolve/redirect/stall_hz, so they do not count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            if (resolve)  branch_cnt_q <= branch_cnt_q + 32'd1;
            if (redirect) taken_cnt_q  <= taken_cnt_q + 32'd1;
            if (stall_hz) stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.branch_cnt = branch_cnt_q;
    assign bus.taken_cnt  = taken_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
`else
    logic unused_stat;
    assign unused_stat    = resolve ^ stall_hz;
    assign bus.branch_cnt = 32'd0;
    assign bus.taken_cnt  = 32'd0;
    assign bus.stall_cnt  = 32'd0;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl. Expected control outputs are queued as
// each cycle's stimulus is applied and compared when the cycle is sampled.
module tb_branch_hazard_ctrl;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    branch_hazard_if bus();

    branch_hazard_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef BRANCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct packed {
        logic        sf;
        logic        sd;
        logic        fe;
        logic        fa;
        logic        fb;
        logic        rd;
        logic [31:0] tg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.isBranchD      = 1'b0;
        bus.isB            = 1'b0;
        bus.rsD            = 5'd0;
        bus.rtD            = 5'd0;
        bus.usesRtD        = 1'b0;
        bus.branch_targetD = 32'd0;
        bus.regwriteE      = 1'b0;
        bus.memtoregE      = 1'b0;
        bus.writeregE      = 5'd0;
        bus.regwriteM      = 1'b0;
        bus.memtoregM      = 1'b0;
        bus.writeregM      = 5'd0;
        bus.stall_ext      = 1'b0;
        bus.flush_exc      = 1'b0;
    endtask

    task automatic expect_out(input logic sf, input logic sd, input logic fe, input logic fa,
                              input logic fb, input logic rd, input logic [31:0] tg);
        exp_t e;
        e = '{sf: sf, sd: sd, fe: fe, fa: fa, fb: fb, rd: rd, tg: tg};
        exp_q.push_back(e);
    endtask

    // Sample on the falling edge, then move to just after the next rising edge.
    task automatic tick(input string tag);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".stallF"},      {31'd0, bus.stallF},      {31'd0, e.sf});
            check({tag, ".stallD"},      {31'd0, bus.stallD},      {31'd0, e.sd});
            check({tag, ".flushE"},      {31'd0, bus.flushE},      {31'd0, e.fe});
            check({tag, ".forwardAD"},   {31'd0, bus.forwardAD},   {31'd0, e.fa});
            check({tag, ".forwardBD"},   {31'd0, bus.forwardBD},   {31'd0, e.fb});
            check({tag, ".pc_redirect"}, {31'd0, bus.pc_redirect}, {31'd0, e.rd});
            check({tag, ".pc_target"},   bus.pc_target,            e.tg);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag, input int b, input int t, input int s);
        check({tag, ".branch_cnt"}, bus.branch_cnt, STAT ? b : 0);
        check({tag, ".taken_cnt"},  bus.taken_cnt,  STAT ? t : 0);
        check({tag, ".stall_cnt"},  bus.stall_cnt,  STAT ? s : 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".stallF"},      {31'd0, bus.stallF},      32'd0);
        check({tag, ".stallD"},      {31'd0, bus.stallD},      32'd0);
        check({tag, ".flushE"},      {31'd0, bus.flushE},      32'd0);
        check({tag, ".forwardAD"},   {31'd0, bus.forwardAD},   32'd0);
        check({tag, ".forwardBD"},   {31'd0, bus.forwardBD},   32'd0);
        check({tag, ".pc_redirect"}, {31'd0, bus.pc_redirect}, 32'd0);
        check({tag, ".pc_target"},   bus.pc_target,            32'd0);
        check({tag, ".branch_cnt"},  bus.branch_cnt,           32'd0);
        check({tag, ".taken_cnt"},   bus.taken_cnt,            32'd0);
        check({tag, ".stall_cnt"},   bus.stall_cnt,            32'd0);
    endtask

    // Holds reset with inputs that would otherwise raise stall/forward outputs.
    task automatic do_reset(input string tag);
        clear_inputs();
        bus.stall_ext = 1'b1;
        bus.rsD       = 5'd8;
        bus.regwriteM = 1'b1;
        bus.writeregM = 5'd8;
        resetn = 1'b0;
        #2;
        check_zero(tag);
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        #1;

        // ---- reset state ----
        do_reset("rst0");

        // ---- EX ALU writes r8, BEQ r8,r9: one stall then forwarded taken ----
        bus.isBranchD = 1'b1; bus.rsD = 5'd8; bus.rtD = 5'd9; bus.usesRtD = 1'b1;
        bus.isB = 1'b1; bus.branch_targetD = 32'h0040_0040;
        bus.regwriteE = 1'b1; bus.writeregE = 5'd8;
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("beq_stall");
        bus.regwriteE = 1'b0; bus.writeregE = 5'd0;
        bus.regwriteM = 1'b1; bus.writeregM = 5'd8;
        expect_out(0, 0, 0, 1, 0, 1, 32'h0040_0040);
        tick("beq_redir");
        clear_inputs();
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("beq_idle");
        check_counters("beq", 1, 1, 1);

        // ---- load in EX writes r8, BNE r8: EX then MEM load stall ----
        do_reset("rst1");
        bus.isBranchD = 1'b1; bus.rsD = 5'd8; bus.rtD = 5'd9; bus.usesRtD = 1'b1;
        bus.isB = 1'b1; bus.branch_targetD = 32'h0040_0080;
        bus.regwriteE = 1'b1; bus.memtoregE = 1'b1; bus.writeregE = 5'd8;
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("ld_stall_ex");
        bus.regwriteE = 1'b0; bus.memtoregE = 1'b0; bus.writeregE = 5'd0;
        bus.regwriteM = 1'b1; bus.memtoregM = 1'b1; bus.writeregM = 5'd8;
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("ld_stall_mem");
        bus.regwriteM = 1'b0; bus.memtoregM = 1'b0; bus.writeregM = 5'd0;
        expect_out(0, 0, 0, 0, 0, 1, 32'h0040_0080);
        tick("ld_resolve");
        check_counters("ld", 1, 1, 2);

        // ---- taken branch under external freeze: HOLD then single redirect ----
        do_reset("rst2");
        bus.isBranchD = 1'b1; bus.rsD = 5'd3; bus.rtD = 5'd4; bus.usesRtD = 1'b1;
        bus.isB = 1'b1; bus.branch_targetD = 32'hBFC0_0100; bus.stall_ext = 1'b1;
        expect_out(1, 1, 0, 0, 0, 0, 32'd0);
        tick("hold_enter");
        bus.isBranchD = 1'b0; bus.isB = 1'b0; bus.branch_targetD = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            expect_out(1, 1, 0, 0, 0, 0, 32'd0);
            tick("hold_wait");
        end
        bus.stall_ext = 1'b0;
        expect_out(0, 0, 0, 0, 0, 1, 32'hBFC0_0100);
        tick("hold_redir");
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("hold_once");
        check_counters("hold", 1, 1, 0);

        // ---- exception flush while holding, and during a hazard ----
        do_reset("rst3");
        bus.isBranchD = 1'b1; bus.rsD = 5'd3; bus.isB = 1'b1;
        bus.branch_targetD = 32'h0040_0100; bus.stall_ext = 1'b1;
        expect_out(1, 1, 0, 0, 0, 0, 32'd0);
        tick("fl_hold");
        bus.isBranchD = 1'b0; bus.isB = 1'b0; bus.flush_exc = 1'b1;
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("fl_flush");
        bus.flush_exc = 1'b0; bus.stall_ext = 1'b0;
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("fl_after1");
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("fl_after2");
        bus.isBranchD = 1'b1; bus.rsD = 5'd8; bus.regwriteE = 1'b1; bus.writeregE = 5'd8;
        bus.flush_exc = 1'b1;
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("fl_hazard");
        clear_inputs();
        check_counters("fl", 1, 0, 0);

        // ---- BGTZ on r0 while EX/MEM write r0: no stall, no forward ----
        do_reset("rst4");
        bus.isBranchD = 1'b1; bus.rsD = 5'd0; bus.rtD = 5'd9; bus.usesRtD = 1'b0;
        bus.regwriteE = 1'b1; bus.writeregE = 5'd0;
        bus.regwriteM = 1'b1; bus.writeregM = 5'd0;
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("r0_nt");
        check_counters("r0", 1, 0, 0);
        // rt ignored without usesRtD, honoured with it
        bus.rsD = 5'd5; bus.writeregE = 5'd9; bus.regwriteM = 1'b0; bus.writeregM = 5'd0;
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("rt_unused");
        bus.usesRtD = 1'b1;
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("rt_hazard");
        bus.regwriteE = 1'b0; bus.writeregE = 5'd0;
        bus.regwriteM = 1'b1; bus.writeregM = 5'd9;
        expect_out(0, 0, 0, 0, 1, 0, 32'd0);
        tick("rt_forward");
        clear_inputs();
        bus.stall_ext = 1'b1;
        expect_out(1, 1, 0, 0, 0, 0, 32'd0);
        tick("ext_pass");
        clear_inputs();

        // ---- reset asserted mid-STALL ----
        do_reset("rst5");
        bus.isBranchD = 1'b1; bus.rsD = 5'd8; bus.regwriteE = 1'b1; bus.writeregE = 5'd8;
        bus.stall_ext = 1'b1;
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("rs_stall1");
        expect_out(1, 1, 1, 0, 0, 0, 32'd0);
        tick("rs_stall2");
        check_counters("rs_pre", 0, 0, 2);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("rs_async");

        // ---- reset asserted in HOLD discards the pending redirect ----
        do_reset("rst6");
        bus.isBranchD = 1'b1; bus.rsD = 5'd3; bus.isB = 1'b1;
        bus.branch_targetD = 32'h0040_0200; bus.stall_ext = 1'b1;
        expect_out(1, 1, 0, 0, 0, 0, 32'd0);
        tick("rh_hold");
        do_reset("rh_rst");
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("rh_after1");
        expect_out(0, 0, 0, 0, 0, 0, 32'd0);
        tick("rh_after2");
        check_counters("rh", 0, 0, 0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
